// File: rtl/counter_pkg.sv
// counter_pkg: mode and state encodings shared by the counter and UART blocks
package counter_pkg;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/counter_nb_if.sv
// counter_nb_if: control, configuration and status bundle of the counter
interface counter_nb_if #(parameter int WIDTH = 8, parameter int PRESCALE_W = 8);
    logic                  ena;
    logic                  start;
    logic                  stop;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      modulus;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  busy;
    logic                  done;
    modport master (output ena, start, stop, load, load_val, dir, mode, modulus, prescale,
                    input count, tc, busy, done);
    modport slave (input ena, start, stop, load, load_val, dir, mode, modulus, prescale,
                   output count, tc, busy, done);
endinterface

// File: rtl/counter_nb_tick_div.sv
// tick_div: prescaler emitting one step strobe every prescale+1 run cycles
module tick_div #(parameter int PRESCALE_W = 8) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step
);
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  hit;
    // A prescale lowered below the running count fires immediately and restarts from 0.
    always_comb begin
        hit   = cnt_q >= prescale;
        step  = ena && run && !clear && hit;
        cnt_d = !ena ? cnt_q : clear ? '0 : !run ? cnt_q : hit ? '0 : cnt_q + PRESCALE_W'(1);
    end
    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/counter_nb.sv
// counter_nb: up/down modulus counter with prescaler, load and wrap/saturate/one-shot modes
module counter_nb
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    counter_nb_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             clear, step, is_wrap, is_os;

    assign clear = bus.ena && (bus.load || bus.stop || (bus.start && state_q != ST_RUN));

    tick_div #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (bus.ena),
        .clear    (clear),
        .run      (state_q == ST_RUN),
        .prescale (bus.prescale),
        .step     (step)
    );

    // Next state, next count and terminal-count pulse in priority load > stop > start > step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        is_os   = bus.mode == MODE_ONESHOT;
        is_wrap = !(bus.mode == MODE_SAT || is_os);
        if (!bus.ena) begin
            state_d = state_q;
        end else if (bus.load) begin
            count_d = bus.load_val > bus.modulus ? bus.modulus : bus.load_val;
            state_d = state_q == ST_DONE ? ST_IDLE : state_q;
        end else if (bus.stop) begin
            state_d = state_q == ST_RUN ? ST_IDLE : state_q;
        end else if (bus.start && state_q != ST_RUN) begin
            state_d = ST_RUN;
        end else if (step) begin
            if (!bus.dir) begin
                if (count_q < bus.modulus) begin
                    count_d = count_q + WIDTH'(1);
                    tc_d    = count_q + WIDTH'(1) == bus.modulus;
                end else if (is_wrap) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = bus.modulus;
                    tc_d    = is_os || count_q != bus.modulus;
                end
            end else begin
                if (count_q > bus.modulus) begin
                    count_d = bus.modulus;
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                    tc_d    = count_q == WIDTH'(1);
                end else if (is_wrap) begin
                    count_d = bus.modulus;
                    tc_d    = 1'b1;
                end else begin
                    tc_d    = is_os;
                end
            end
            state_d = is_os && tc_d ? ST_DONE : state_q;
        end
    end

    // State, count and tc registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = state_q == ST_RUN;
    assign bus.done  = state_q == ST_DONE;
endmodule

// File: tb/tb_counter_nb.sv
// tb_counter_nb: directed scoreboard bench for counter_nb
module tb_counter_nb;
    typedef struct {
        string      name;
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t q[$];
    int   checks = 0;
    int   fails = 0;

    counter_nb_if #(.WIDTH(8), .PRESCALE_W(8)) bus ();
    counter_nb #(.WIDTH(8), .PRESCALE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Monitor: every edge, compare outputs against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({bus.count, bus.tc, bus.busy, bus.done} !== {e.count, e.tc, e.busy, e.done}) begin
                fails++;
                $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                         e.name, bus.count, bus.tc, bus.busy, bus.done, e.count, e.tc, e.busy, e.done);
            end
        end
    end

    task automatic tick(input string n, input int c, input bit t, input bit b, input bit d);
        exp_t e;
        e.name = n;
        e.count = 8'(c);
        e.tc = t;
        e.busy = b;
        e.done = d;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cur;
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
        bus.load_val = 8'd0; bus.dir = 1'b0; bus.mode = 2'b00;
        bus.modulus = 8'd7; bus.prescale = 8'd0;
        tick("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        // wrap up, modulus 7, prescale 0
        bus.start = 1'b1; tick("wrap_start", 0, 0, 1, 0); bus.start = 1'b0;
        for (int i = 1; i <= 9; i++) tick("wrap_up", i % 8, (i % 8 == 7) || (i % 8 == 0), 1, 0);
        bus.stop = 1'b1; tick("wrap_stop", 1, 0, 0, 0); bus.stop = 1'b0;
        // saturate down, modulus 9, prescale 3
        bus.modulus = 8'd9; bus.prescale = 8'd3; bus.dir = 1'b1; bus.mode = 2'b01;
        bus.load_val = 8'd5; bus.load = 1'b1; tick("sat_load", 5, 0, 0, 0); bus.load = 1'b0;
        bus.start = 1'b1; tick("sat_start", 5, 0, 1, 0); bus.start = 1'b0;
        cur = 5;
        for (int s = 0; s < 5; s++) begin
            repeat (3) tick("sat_wait", cur, 0, 1, 0);
            cur--;
            tick("sat_step", cur, cur == 0, 1, 0);
        end
        repeat (8) tick("sat_hold0", 0, 0, 1, 0);
        bus.stop = 1'b1; tick("sat_stop", 0, 0, 0, 0); bus.stop = 1'b0;
        // one-shot up, modulus 4
        bus.modulus = 8'd4; bus.prescale = 8'd0; bus.dir = 1'b0; bus.mode = 2'b10;
        bus.load_val = 8'd2; bus.load = 1'b1; tick("os_load", 2, 0, 0, 0); bus.load = 1'b0;
        bus.start = 1'b1; tick("os_start", 2, 0, 1, 0); bus.start = 1'b0;
        tick("os_step3", 3, 0, 1, 0);
        tick("os_done", 4, 1, 0, 1);
        tick("os_hold", 4, 0, 0, 1);
        tick("os_hold", 4, 0, 0, 1);
        bus.start = 1'b1; tick("os_restart", 4, 0, 1, 0); bus.start = 1'b0;
        tick("os_redone", 4, 1, 0, 1);
        bus.load_val = 8'd1; bus.load = 1'b1; tick("os_load_idle", 1, 0, 0, 0); bus.load = 1'b0;
        // load clamp and start/stop collision
        bus.mode = 2'b00; bus.modulus = 8'd50; bus.load_val = 8'd200;
        bus.load = 1'b1; tick("load_clamp", 50, 0, 0, 0); bus.load = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b1; tick("start_stop", 50, 0, 0, 0);
        bus.start = 1'b0; bus.stop = 1'b0; tick("still_idle", 50, 0, 0, 0);
        // reset with ena low mid-run, then ena freeze
        bus.start = 1'b1; tick("run50", 50, 0, 1, 0); bus.start = 1'b0;
        tick("wrap50", 0, 1, 1, 0);
        tick("run1", 1, 0, 1, 0);
        bus.ena = 1'b0; rst_n = 1'b0; tick("reset_ena0", 0, 0, 0, 0);
        bus.ena = 1'b1; rst_n = 1'b1;
        bus.start = 1'b1; tick("restart", 0, 0, 1, 0); bus.start = 1'b0;
        tick("run_a", 1, 0, 1, 0);
        tick("run_b", 2, 0, 1, 0);
        bus.ena = 1'b0;
        repeat (4) tick("ena_freeze", 2, 0, 1, 0);
        bus.ena = 1'b1; tick("ena_resume", 3, 0, 1, 0);
        // modulus lowered below count: wrap then saturate
        bus.load_val = 8'd30; bus.load = 1'b1; tick("load30_run", 30, 0, 1, 0); bus.load = 1'b0;
        bus.modulus = 8'd10; tick("mod_drop_wrap", 0, 1, 1, 0);
        bus.modulus = 8'd50; bus.load = 1'b1; tick("load30_again", 30, 0, 1, 0); bus.load = 1'b0;
        bus.modulus = 8'd10; bus.mode = 2'b01; tick("mod_drop_sat", 10, 1, 1, 0);
        tick("sat_hold_top", 10, 0, 1, 0);
        bus.stop = 1'b1; tick("stop10", 10, 0, 0, 0); bus.stop = 1'b0;
        // prescale reduced below running prescaler
        bus.mode = 2'b00; bus.modulus = 8'd50; bus.prescale = 8'd5;
        bus.start = 1'b1; tick("ps_start", 10, 0, 1, 0); bus.start = 1'b0;
        repeat (3) tick("ps_wait", 10, 0, 1, 0);
        bus.prescale = 8'd1; tick("ps_forced", 11, 0, 1, 0);
        tick("ps_wait1", 11, 0, 1, 0);
        tick("ps_step", 12, 0, 1, 0);
        // wrap down, then modulus dropped below count while counting down
        bus.prescale = 8'd0; bus.dir = 1'b1;
        bus.load_val = 8'd1; bus.load = 1'b1; tick("dn_load1", 1, 0, 1, 0); bus.load = 1'b0;
        tick("dn_zero", 0, 1, 1, 0);
        tick("dn_wrap", 50, 1, 1, 0);
        tick("dn_49", 49, 0, 1, 0);
        bus.modulus = 8'd20; tick("dn_clip", 20, 0, 1, 0);
        tick("dn_19", 19, 0, 1, 0);
        bus.stop = 1'b1; tick("dn_stop", 19, 0, 0, 0); bus.stop = 1'b0;
        // modulus 0 in wrap mode pulses tc every step
        bus.dir = 1'b0; bus.modulus = 8'd0;
        bus.load = 1'b1; tick("m0_load", 0, 0, 0, 0); bus.load = 1'b0;
        bus.start = 1'b1; tick("m0_start", 0, 0, 1, 0); bus.start = 1'b0;
        tick("m0_tc", 0, 1, 1, 0);
        tick("m0_tc", 0, 1, 1, 0);
        bus.stop = 1'b1; tick("m0_stop", 0, 0, 0, 0); bus.stop = 1'b0;
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
